regs_param: RTL and testbench
=============================

Name: regs_param

Overview:
- Parametrised successor to the team's 32x32 two-read/one-write register file.
- Generalises width and depth, and adds byte-enabled writes, same-cycle write-to-read bypass and an optional hardwired-zero register 0.
- Adds a sequential bulk-clear engine that wipes the array one entry per cycle.
- Sits in the CPU datapath between decode (read addresses) and writeback (write port).

Parameters:
DATA_W, 32, data width in bits; must be a multiple of 8.
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
ZERO_REG, 1, 1: entry 0 always reads 0 and ignores writes; 0: entry 0 is an ordinary register.
BYPASS, 1, 1: a write in the current cycle is forwarded combinationally to matching read ports.

Ports:
Clk  in  1  rising-edge clock
Reset  in  1  asynchronous, active-high reset
R_Addr_A  in  ADDR_W  read address, port A
R_Addr_B  in  ADDR_W  read address, port B
R_Data_A  out  DATA_W  read data, port A (combinational)
R_Data_B  out  DATA_W  read data, port B (combinational)
W_Addr  in  ADDR_W  write address
W_Data  in  DATA_W  write data
W_Byte_En  in  DATA_W/8  per-byte write enable; bit i covers W_Data[8i+7:8i]
Write_reg  in  1  write request, sampled at the Clk rising edge
Clear_req  in  1  bulk-clear request, sampled at the Clk rising edge
Busy  out  1  registered; 1 while the clear engine runs
Write_drop  out  1  registered one-cycle pulse: a write was discarded because of a clear

Behaviour:
Reset:
- While Reset=1: all entries = 0, state = IDLE, clear counter = 0, Busy = 0, Write_drop = 0.
- Therefore R_Data_A and R_Data_B read 0.

Reads:
- Combinational from the array, zero-cycle latency.
- If ZERO_REG=1 and the address is 0, the read returns 0 regardless of bypass.

Writes:
- A write is effective when Write_reg=1 and state=IDLE at the rising edge.
- Only bytes with W_Byte_En=1 are updated; all other bytes keep their value.
- W_Byte_En = all-zero is a no-op and does not pulse Write_drop.
- If ZERO_REG=1 and W_Addr=0, the write is discarded silently.

Bypass (BYPASS=1):
- Condition: Write_reg=1, state=IDLE, W_Addr equals the read address, and the address is not a zero-reg hit.
- Result: that read port returns the byte-merge of W_Data (enabled bytes) and the stored word (other bytes) in the same cycle.
- With BYPASS=0, the read returns the old stored value until after the edge.
- Bypass is disabled whenever Busy=1.

Clear engine (states IDLE, CLEAR):
- IDLE -> CLEAR: on a rising edge with Clear_req=1. A Write_reg sampled at that same edge still completes (state was IDLE). Counter is set to 0 and Busy becomes 1.
- In CLEAR, each rising edge writes 0 to entry[counter] and increments the counter. Entries 0..DEPTH-1 are cleared on the DEPTH consecutive edges after entry into CLEAR.
- CLEAR -> IDLE: at the edge that clears entry DEPTH-1. Busy falls there, and the counter wraps to 0.
- Busy is high for exactly DEPTH cycles.
- Clear_req while in CLEAR is ignored; it does not restart or extend the clear.
- Write_reg=1 at any edge taken in CLEAR state, including the final one, is dropped. Write_drop=1 for the following cycle only, otherwise 0.
- Reads during CLEAR return the current array contents, which may be partially cleared.
- Reset asserted mid-clear: immediate return to the full reset state. No clearing resumes after Reset is released.

Test Plan:
- Reset, then write r1=0x1111_1111 and r2=0x2222_2222 (W_Byte_En=4'hF) on successive edges. Then R_Addr_A=1, R_Addr_B=2 -> R_Data_A=0x1111_1111, R_Data_B=0x2222_2222. Assert Reset -> both outputs read 0 immediately, without waiting for a clock edge.
- Write r3=0xAABB_CCDD, then write 0x1122_3344 with W_Byte_En=4'b0101 -> r3 reads 0xAA22_CC44. Write r3 with W_Byte_En=0 -> r3 unchanged, Write_drop stays 0.
- BYPASS=1: hold Write_reg=1, W_Addr=4, W_Data=0x5555_5555, R_Addr_A=4 before the edge -> R_Data_A=0x5555_5555 pre-edge. Repeat with BYPASS=0 -> old value pre-edge, new value post-edge.
- ZERO_REG=1: write r0=0xFFFF_FFFF with the bypass condition true -> R_Data_A at address 0 reads 0 both before and after the edge. ZERO_REG=0: same sequence -> reads 0xFFFF_FFFF.
- Fill all 32 entries with nonzero data, then pulse Clear_req -> Busy high for exactly 32 cycles. Mid-clear, entry 0 reads 0 while entry 31 still holds its data. A Write_reg to r7 at clear cycle 10 -> Write_drop pulses one cycle, r7 ends 0. A second Clear_req mid-clear -> Busy duration unchanged. After Busy falls, all reads are 0.
- Start a clear, assert Reset asynchronously at clear cycle 5 (between edges) -> Busy=0 and outputs 0 at once. After release, a normal write/read of r9=0x9999_9999 succeeds.

Source files
------------

// File: rtl/regs_param.sv
// Parametrised 2R/1W register file with byte enables, write bypass,
// optional hardwired zero entry and a one-entry-per-cycle bulk clear.
module regs_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] R_Addr_A,
    input  logic [ADDR_W-1:0] R_Addr_B,
    output logic [DATA_W-1:0] R_Data_A,
    output logic [DATA_W-1:0] R_Data_B,
    input  logic [ADDR_W-1:0] W_Addr,
    input  logic [DATA_W-1:0] W_Data,
    input  logic [DATA_W/8-1:0] W_Byte_En,
    input  logic              Write_reg,
    input  logic              Clear_req,
    output logic              Busy,
    output logic              Write_drop
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;
    localparam logic [ADDR_W-1:0] LAST = '1;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    function automatic logic [DATA_W-1:0] merge(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [NB-1:0]     en
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int b = 0; b < NB; b++) begin
            if (en[b]) res[8*b +: 8] = new_word[8*b +: 8];
        end
        return res;
    endfunction

    function automatic logic zero_hit(input logic [ADDR_W-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    logic write_ok;
    assign write_ok = Write_reg && (state == IDLE) && !zero_hit(W_Addr);

    function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] res;
        res = mem[addr];
        if (zero_hit(addr)) begin
            res = '0;
        end else if ((BYPASS != 0) && write_ok && (W_Addr == addr)) begin
            res = merge(mem[addr], W_Data, W_Byte_En);
        end
        return res;
    endfunction

    assign R_Data_A = rd(R_Addr_A);
    assign R_Data_B = rd(R_Addr_B);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            state      <= IDLE;
            cnt        <= '0;
            Busy       <= 1'b0;
            Write_drop <= 1'b0;
        end else begin
            Write_drop <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (write_ok) begin
                        mem[W_Addr] <= merge(mem[W_Addr], W_Data, W_Byte_En);
                    end
                    if (Clear_req) begin
                        state <= CLEAR;
                        cnt   <= '0;
                        Busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    mem[cnt]   <= '0;
                    Write_drop <= Write_reg && (|W_Byte_En);
                    if (cnt == LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                        Busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regs_param.sv
// Directed bench for regs_param: three parameter variants share inputs.
module tb_regs_param;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [4:0]  R_Addr_A = '0;
    logic [4:0]  R_Addr_B = '0;
    logic [4:0]  W_Addr = '0;
    logic [31:0] W_Data = '0;
    logic [3:0]  W_Byte_En = '0;
    logic        Write_reg = 1'b0;
    logic        Clear_req = 1'b0;

    logic [31:0] a_d, b_d, a_nb, b_nb, a_nz, b_nz;
    logic        busy_d, busy_nb, busy_nz;
    logic        drop_d, drop_nb, drop_nz;

    int n_chk = 0;
    int n_fail = 0;

    always #5 Clk = ~Clk;

    regs_param #(.ZERO_REG(1), .BYPASS(1)) u_dflt (
        .Clk(Clk), .Reset(Reset),
        .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B),
        .R_Data_A(a_d), .R_Data_B(b_d),
        .W_Addr(W_Addr), .W_Data(W_Data), .W_Byte_En(W_Byte_En),
        .Write_reg(Write_reg), .Clear_req(Clear_req),
        .Busy(busy_d), .Write_drop(drop_d)
    );

    regs_param #(.ZERO_REG(1), .BYPASS(0)) u_nobyp (
        .Clk(Clk), .Reset(Reset),
        .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B),
        .R_Data_A(a_nb), .R_Data_B(b_nb),
        .W_Addr(W_Addr), .W_Data(W_Data), .W_Byte_En(W_Byte_En),
        .Write_reg(Write_reg), .Clear_req(Clear_req),
        .Busy(busy_nb), .Write_drop(drop_nb)
    );

    regs_param #(.ZERO_REG(0), .BYPASS(1)) u_nozero (
        .Clk(Clk), .Reset(Reset),
        .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B),
        .R_Data_A(a_nz), .R_Data_B(b_nz),
        .W_Addr(W_Addr), .W_Data(W_Data), .W_Byte_En(W_Byte_En),
        .Write_reg(Write_reg), .Clear_req(Clear_req),
        .Busy(busy_nz), .Write_drop(drop_nz)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d,
                      input logic [3:0] en);
        W_Addr = a; W_Data = d; W_Byte_En = en; Write_reg = 1'b1;
        tick();
        Write_reg = 1'b0;
        #1;
    endtask

    int busy_cnt;

    initial begin
        #2;
        check("rst_a", a_d, 32'h0);
        check("rst_busy", {31'b0, busy_d}, 32'h0);
        check("rst_drop", {31'b0, drop_d}, 32'h0);
        tick();
        Reset = 1'b0;
        #1;

        wr(5'd1, 32'h1111_1111, 4'hF);
        wr(5'd2, 32'h2222_2222, 4'hF);
        R_Addr_A = 5'd1; R_Addr_B = 5'd2;
        #1;
        check("rd_r1", a_d, 32'h1111_1111);
        check("rd_r2", b_d, 32'h2222_2222);
        #2 Reset = 1'b1;
        #1;
        check("async_rst_a", a_d, 32'h0);
        check("async_rst_b", b_d, 32'h0);
        tick();
        Reset = 1'b0;
        #1;

        wr(5'd3, 32'hAABB_CCDD, 4'hF);
        wr(5'd3, 32'h1122_3344, 4'b0101);
        R_Addr_A = 5'd3;
        #1;
        check("byte_en", a_d, 32'hAA22_CC44);
        wr(5'd3, 32'h0000_0000, 4'h0);
        check("en0_keep", a_d, 32'hAA22_CC44);
        check("en0_drop", {31'b0, drop_d}, 32'h0);

        R_Addr_A = 5'd4;
        W_Addr = 5'd4; W_Data = 32'h5555_5555; W_Byte_En = 4'hF;
        Write_reg = 1'b1;
        #1;
        check("byp_pre", a_d, 32'h5555_5555);
        check("nobyp_pre", a_nb, 32'h0);
        tick();
        Write_reg = 1'b0;
        #1;
        check("nobyp_post", a_nb, 32'h5555_5555);
        check("byp_post", a_d, 32'h5555_5555);

        R_Addr_A = 5'd0;
        W_Addr = 5'd0; W_Data = 32'hFFFF_FFFF; W_Byte_En = 4'hF;
        Write_reg = 1'b1;
        #1;
        check("zr_pre", a_d, 32'h0);
        check("nz_pre", a_nz, 32'hFFFF_FFFF);
        tick();
        Write_reg = 1'b0;
        #1;
        check("zr_post", a_d, 32'h0);
        check("nz_post", a_nz, 32'hFFFF_FFFF);

        for (int i = 0; i < 32; i++) begin
            wr(i[4:0], 32'hA500_0000 | (i + 1), 4'hF);
        end
        R_Addr_A = 5'd0; R_Addr_B = 5'd31;
        #1;
        check("fill_r0", a_nz, 32'hA500_0001);
        Clear_req = 1'b1;
        tick();
        Clear_req = 1'b0;
        busy_cnt = busy_d ? 1 : 0;
        check("clr_busy", {31'b0, busy_d}, 32'h1);
        for (int k = 1; k <= 40; k++) begin
            if (k == 10) begin
                W_Addr = 5'd7; W_Data = 32'h7777_7777;
                W_Byte_En = 4'hF; Write_reg = 1'b1;
            end
            if (k == 11) Write_reg = 1'b0;
            Clear_req = (k == 15);
            tick();
            if (k == 1) begin
                check("mid_r0", a_nz, 32'h0);
                check("mid_r31", b_d, 32'hA500_0020);
            end
            if (k == 10) check("drop_pulse", {31'b0, drop_d}, 32'h1);
            if (k == 11) check("drop_end", {31'b0, drop_d}, 32'h0);
            if (!busy_d) break;
            busy_cnt++;
        end
        Clear_req = 1'b0;
        check("busy_len", busy_cnt, 32);
        check("busy_nz_off", {31'b0, busy_nz}, 32'h0);
        for (int i = 0; i < 32; i++) begin
            R_Addr_A = i[4:0];
            #1;
            check($sformatf("clr_r%0d", i), a_nz, 32'h0);
        end
        R_Addr_A = 5'd7;
        #1;
        check("r7_zero", a_d, 32'h0);

        wr(5'd20, 32'h2020_2020, 4'hF);
        R_Addr_A = 5'd20;
        Clear_req = 1'b1;
        tick();
        Clear_req = 1'b0;
        repeat (5) tick();
        check("pre_rst_r20", a_d, 32'h2020_2020);
        check("pre_rst_busy", {31'b0, busy_d}, 32'h1);
        #3 Reset = 1'b1;
        #1;
        check("mrst_busy", {31'b0, busy_d}, 32'h0);
        check("mrst_r20", a_d, 32'h0);
        tick();
        Reset = 1'b0;
        repeat (3) tick();
        check("post_rst_busy", {31'b0, busy_d}, 32'h0);
        wr(5'd9, 32'h9999_9999, 4'hF);
        R_Addr_B = 5'd9;
        #1;
        check("r9", b_d, 32'h9999_9999);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
